fetch_stage: RTL and testbench

- Front-end fetch stage sitting directly upstream of the instruction memory in the fetch datapath.
- Owns the program counter and drives the memory address; the memory returns the instruction combinationally in the same cycle.
- Registers {pc, instr} into a valid/ready pipeline register feeding decode.
- Handles stalls from decode, redirects (branch/jump) from execute, and a global fetch enable.

---
 rtl/fetch_stage.sv | 118 +++++++++++
 tb/tb_fetch_stage.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: owns the program counter, drives the instruction memory
// address, and registers {pc, instr} into a valid/ready output register
// that feeds decode. Handles decode stalls, execute redirects and a
// global fetch enable. It also counts completed fetch->decode handshakes.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        fetch_en_i,
    output logic [31:0] imem_pc_o,
    input  logic [31:0] imem_instr_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        decode_ready_i,
    output logic        fetch_valid_o,
    output logic [31:0] fetch_pc_o,
    output logic [31:0] fetch_instr_o,
    output logic        fetch_misaligned_o,
    output logic [31:0] fetch_count_o
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0] pc_reg,        pc_next;
    logic        out_valid_reg, out_valid_next;
    logic [31:0] out_pc_reg,    out_pc_next;
    logic [31:0] out_instr_reg, out_instr_next;
    logic        out_mis_reg,   out_mis_next;
    logic [31:0] count_reg,     count_next;

    // ------------------------------------------------------------------
    // Handshake terms
    // ------------------------------------------------------------------
    logic        fire;       // decode takes the current entry this cycle
    logic        adv;        // output register may be overwritten
    logic        pc_mis;     // current PC is not word aligned
    logic [31:0] pc_plus4;   // sequential successor, wraps modulo 2^32

    assign pc_mis   = (pc_reg[1:0] != 2'b00);
    assign pc_plus4 = pc_reg + 32'd4;

    // A redirect squashes the presented entry in the same cycle, so the
    // visible valid is masked by the redirect and fire can never coincide
    // with a redirect.
    assign fetch_valid_o = out_valid_reg & ~redirect_valid_i;
    assign fire          = fetch_valid_o & decode_ready_i;
    assign adv           = ~out_valid_reg | decode_ready_i;

    // ------------------------------------------------------------------
    // Outputs driven straight from state
    // ------------------------------------------------------------------
    assign imem_pc_o          = pc_reg;
    assign fetch_pc_o         = out_pc_reg;
    assign fetch_instr_o      = out_instr_reg;
    assign fetch_misaligned_o = out_mis_reg;
    assign fetch_count_o      = count_reg;

    // Next-state selection: redirect > advance with fetch > advance idle > stall
    always_comb begin
        pc_next        = pc_reg;
        out_valid_next = out_valid_reg;
        out_pc_next    = out_pc_reg;
        out_instr_next = out_instr_reg;
        out_mis_next   = out_mis_reg;

        if (redirect_valid_i) begin
            // Target replaces the PC; whatever sat in the output register
            // (stalled or not) is discarded.
            pc_next        = redirect_pc_i;
            out_valid_next = 1'b0;
        end else if (adv && fetch_en_i) begin
            // Latch the word the memory returns for the current PC. A
            // misaligned PC carries a NOP plus the flag; trap handling is
            // left to later stages and fetching continues by +4.
            out_valid_next = 1'b1;
            out_pc_next    = pc_reg;
            out_mis_next   = pc_mis;
            out_instr_next = pc_mis ? NOP_INSTR : imem_instr_i;
            pc_next        = pc_plus4;
        end else if (adv) begin
            // Fetch disabled: drain the output register, freeze the PC.
            out_valid_next = 1'b0;
        end
        // Otherwise decode is stalling: everything holds so the presented
        // entry is neither lost nor duplicated.
    end

    // Handshake counter; wraps naturally at 2^32
    always_comb begin
        count_next = count_reg;
        if (fire) begin
            count_next = count_reg + 32'd1;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pc_reg        <= RESET_PC;
            out_valid_reg <= 1'b0;
            out_pc_reg    <= 32'd0;
            out_instr_reg <= 32'd0;
            out_mis_reg   <= 1'b0;
            count_reg     <= 32'd0;
        end else begin
            pc_reg        <= pc_next;
            out_valid_reg <= out_valid_next;
            out_pc_reg    <= out_pc_next;
            out_instr_reg <= out_instr_next;
            out_mis_reg   <= out_mis_next;
            count_reg     <= count_next;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage: linear sequence of steps with
// hand-computed expectations checked by immediate assertions.
module tb_fetch_stage;

    logic        clk;
    logic        rstn;
    logic        fetch_en;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        decode_ready;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_instr;
    logic        fetch_misaligned;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    fetch_stage dut (
        .clk_i              (clk),
        .rstn_i             (rstn),
        .fetch_en_i         (fetch_en),
        .imem_pc_o          (imem_pc),
        .imem_instr_i       (imem_instr),
        .redirect_valid_i   (redirect_valid),
        .redirect_pc_i      (redirect_pc),
        .decode_ready_i     (decode_ready),
        .fetch_valid_o      (fetch_valid),
        .fetch_pc_o         (fetch_pc),
        .fetch_instr_o      (fetch_instr),
        .fetch_misaligned_o (fetch_misaligned),
        .fetch_count_o      (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: two fixed words, everything else addr ^ DEAD0000
    always_comb begin
        case (imem_pc)
            32'h0000_0000: imem_instr = 32'h1234_50b7;
            32'h0000_0004: imem_instr = 32'h6780_8093;
            default:       imem_instr = imem_pc ^ 32'hDEAD_0000;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic v, input logic [31:0] ipc,
                             input logic [31:0] cnt);
        chk({tag, ".valid"}, {31'd0, fetch_valid}, {31'd0, v});
        chk({tag, ".imem_pc"}, imem_pc, ipc);
        chk({tag, ".count"}, fetch_count, cnt);
        $display("step %-10s valid=%0b pc=%h instr=%h mis=%0b imem_pc=%h count=%0d",
                 tag, fetch_valid, fetch_pc, fetch_instr, fetch_misaligned, imem_pc, fetch_count);
    endtask

    task automatic chk_entry(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                             input logic mis);
        chk({tag, ".pc"}, fetch_pc, pc);
        chk({tag, ".instr"}, fetch_instr, instr);
        chk({tag, ".mis"}, {31'd0, fetch_misaligned}, {31'd0, mis});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn           = 1'b0;
        fetch_en       = 1'b1;
        decode_ready   = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        #2;
        chk_state("reset", 1'b0, 32'h0, 32'd0);
        chk_entry("reset", 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;

        // Sequential fetch
        step();
        chk_state("seq0", 1'b1, 32'h4, 32'd0);
        chk_entry("seq0", 32'h0, 32'h1234_50b7, 1'b0);
        step();
        chk_state("seq1", 1'b1, 32'h8, 32'd1);
        chk_entry("seq1", 32'h4, 32'h6780_8093, 1'b0);
        step();
        chk_state("seq2", 1'b1, 32'hC, 32'd2);
        chk_entry("seq2", 32'h8, 32'hDEAD_0008, 1'b0);

        // Stall three cycles with pc=8 presented
        decode_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_state("stall", 1'b1, 32'hC, 32'd2);
            chk_entry("stall", 32'h8, 32'hDEAD_0008, 1'b0);
        end
        decode_ready = 1'b1;
        step();
        chk_state("release", 1'b1, 32'h10, 32'd3);
        chk_entry("release", 32'hC, 32'hDEAD_000C, 1'b0);
        step();
        chk_state("seq3", 1'b1, 32'h14, 32'd4);
        chk_entry("seq3", 32'h10, 32'hDEAD_0010, 1'b0);

        // Redirect to 0x40 while 0x10 is presented
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        #1;
        chk_state("redir_sq", 1'b0, 32'h14, 32'd4);
        step();
        redirect_valid = 1'b0;
        #1;
        chk_state("redir_n1", 1'b0, 32'h40, 32'd4);
        step();
        chk_state("redir_n2", 1'b1, 32'h44, 32'd4);
        chk_entry("redir_n2", 32'h40, 32'hDEAD_0040, 1'b0);
        step();
        chk_state("redir_n3", 1'b1, 32'h48, 32'd5);
        chk_entry("redir_n3", 32'h44, 32'hDEAD_0044, 1'b0);

        // Misaligned redirect to 0x42
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        step();
        redirect_valid = 1'b0;
        #1;
        chk_state("mis_n1", 1'b0, 32'h42, 32'd5);
        step();
        chk_state("mis_n2", 1'b1, 32'h46, 32'd5);
        chk_entry("mis_n2", 32'h42, 32'h0000_0013, 1'b1);
        step();
        chk_state("mis_n3", 1'b1, 32'h4A, 32'd6);
        chk_entry("mis_n3", 32'h46, 32'h0000_0013, 1'b1);

        // Wrap: redirect to FFFF_FFFC
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        step();
        chk_state("wrap0", 1'b1, 32'h0, 32'd6);
        chk_entry("wrap0", 32'hFFFF_FFFC, 32'h2152_FFFC, 1'b0);
        step();
        chk_state("wrap1", 1'b1, 32'h4, 32'd7);
        chk_entry("wrap1", 32'h0, 32'h1234_50b7, 1'b0);

        // Back-to-back redirects: last one wins
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        step();
        redirect_pc    = 32'h200;
        step();
        redirect_valid = 1'b0;
        #1;
        chk_state("b2b_n1", 1'b0, 32'h200, 32'd7);
        step();
        chk_state("b2b_n2", 1'b1, 32'h204, 32'd7);
        chk_entry("b2b_n2", 32'h200, 32'hDEAD_0200, 1'b0);

        // Fetch disabled while stalled: held entry stays until consumed
        decode_ready = 1'b0;
        fetch_en     = 1'b0;
        step();
        chk_state("dis_stall", 1'b1, 32'h204, 32'd7);
        chk_entry("dis_stall", 32'h200, 32'hDEAD_0200, 1'b0);
        decode_ready = 1'b1;
        step();
        chk_state("dis_drain", 1'b0, 32'h204, 32'd8);
        step();
        chk_state("dis_idle", 1'b0, 32'h204, 32'd8);
        fetch_en = 1'b1;
        step();
        chk_state("re_en0", 1'b1, 32'h208, 32'd8);
        chk_entry("re_en0", 32'h204, 32'hDEAD_0204, 1'b0);

        // Redirect during stall: stalled entry discarded, PC replaced
        decode_ready   = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        #1;
        chk_state("rs_sq", 1'b0, 32'h208, 32'd8);
        step();
        redirect_valid = 1'b0;
        decode_ready   = 1'b1;
        #1;
        chk_state("rs_n1", 1'b0, 32'h300, 32'd8);
        step();
        chk_state("rs_n2", 1'b1, 32'h304, 32'd8);
        chk_entry("rs_n2", 32'h300, 32'hDEAD_0300, 1'b0);
        step();
        chk_state("rs_n3", 1'b1, 32'h308, 32'd9);

        // Asynchronous reset mid-stream
        rstn = 1'b0;
        #1;
        chk_state("arst", 1'b0, 32'h0, 32'd0);
        chk_entry("arst", 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        step();
        chk_state("arst_n1", 1'b1, 32'h4, 32'd0);
        chk_entry("arst_n1", 32'h0, 32'h1234_50b7, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
